// File: rtl/bcd_freq_counter_mc.sv
// Multi-channel BCD frequency counter core.
// Counts rising edges of one selected asynchronous input over a gate window of
// GATE_CYCLES/10^range reference cycles. The count is held in packed BCD and
// saturates at all-nines with an overflow flag. Each finished window is
// published through a valid/ack handshake in which the newest result wins.
module bcd_freq_counter_mc #(
  parameter  int CHANNELS    = 4,
  parameter  int DIGITS      = 6,
  parameter  int GATE_CYCLES = 1000000,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_ref_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic [CHANNELS-1:0]   clk_x_in,
  input  logic [SEL_W-1:0]      ch_sel_in,
  input  logic [1:0]            range_in,
  output logic [4*DIGITS-1:0]   result_bcd_out,
  output logic [SEL_W-1:0]      result_ch_out,
  output logic [1:0]            dp_out,
  output logic                  overflow_out,
  output logic                  result_valid_out,
  input  logic                  result_ack_in,
  output logic                  busy_out
);

  localparam int RW  = 4 * DIGITS;
  localparam int GCW = $clog2(GATE_CYCLES);

  // Gate counter reload values: window length minus one. All four are
  // elaboration-time constants, so no divider is built.
  localparam logic [GCW-1:0] GATE_LOAD_R0 = GCW'(GATE_CYCLES - 1);
  localparam logic [GCW-1:0] GATE_LOAD_R1 = GCW'(GATE_CYCLES / 10 - 1);
  localparam logic [GCW-1:0] GATE_LOAD_R2 = GCW'(GATE_CYCLES / 100 - 1);
  localparam logic [GCW-1:0] GATE_LOAD_R3 = GCW'(GATE_CYCLES / 1000 - 1);

  // One extra bit lets the select be compared against CHANNELS even when
  // CHANNELS is a power of two.
  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_GATE  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [SEL_W-1:0]    ch_q;
  logic [1:0]          rng_q;
  logic [RW-1:0]       count_q;
  logic                ovf_q;
  logic [GCW-1:0]      gate_cnt_q;
  logic                edge_q;

  logic [SEL_W-1:0]    arm_ch;
  logic [GCW-1:0]      gate_load;
  logic                sel_arm;
  logic                sel_cur;
  logic                rise;
  logic                gate_done;
  logic [RW-1:0]       count_inc;
  logic                all_nines;
  logic                carry;

  logic                arm_en;
  logic                count_en;
  logic                latch_en;

  // Two-flop synchroniser on every channel, running regardless of FSM state
  // so a newly selected channel is already settled when its window opens.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync2_q take the old sync1_q; with
      // blocking ones the two flops would collapse into a single stage.
      sync1_q <= clk_x_in;
      sync2_q <= sync1_q;
    end
  end

  // Channel chosen at ARM: out-of-range selects fall back to channel 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    arm_ch = '0;
    if ({1'b0, ch_sel_in} < CH_LIMIT) begin
      arm_ch = ch_sel_in;
    end
  end

  // Gate length selection from the range input.
  always_comb begin
    gate_load = GATE_LOAD_R0;
    case (range_in)
      2'd0:    gate_load = GATE_LOAD_R0;
      2'd1:    gate_load = GATE_LOAD_R1;
      2'd2:    gate_load = GATE_LOAD_R2;
      default: gate_load = GATE_LOAD_R3;
    endcase
  end

  // Edge detection on the synchronised, selected channel.
  always_comb begin
    sel_arm   = sync2_q[arm_ch];
    sel_cur   = sync2_q[ch_q];
    rise      = sel_cur & ~edge_q;
    gate_done = (gate_cnt_q == '0);
  end

  // Ripple-carry BCD increment and all-nines detection for saturation.
  always_comb begin
    count_inc = count_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd9) begin
        all_nines = 1'b0;
      end
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: dropping enable aborts ARM/GATE without a result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable_in) state_d = S_ARM;
      S_ARM:   state_d = enable_in ? S_GATE : S_IDLE;
      S_GATE: begin
        if (!enable_in) begin
          state_d = S_IDLE;
        end else if (gate_done) begin
          state_d = S_LATCH;
        end
      end
      default: state_d = enable_in ? S_ARM : S_IDLE;
    endcase
  end

  // FSM outputs: per-state enables for the datapath and the busy flag.
  always_comb begin
    arm_en   = (state_q == S_ARM);
    count_en = (state_q == S_GATE);
    latch_en = (state_q == S_LATCH);
    busy_out = (state_q != S_IDLE);
  end

  // Measurement datapath: window setup in ARM, edge counting in GATE.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      ch_q       <= '0;
      rng_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      gate_cnt_q <= '0;
      edge_q     <= 1'b0;
    end else if (arm_en) begin
      ch_q       <= arm_ch;
      rng_q      <= range_in;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      gate_cnt_q <= gate_load;
      // Preload with the new channel's level so switching channels never
      // looks like a rising edge.
      edge_q     <= sel_arm;
    end else begin
      edge_q <= sel_cur;
      if (count_en) begin
        if (!gate_done) begin
          gate_cnt_q <= gate_cnt_q - GCW'(1);
        end
        if (rise) begin
          if (all_nines) begin
            ovf_q <= 1'b1;
          end else begin
            count_q <= count_inc;
          end
        end
      end
    end
  end

  // Result registers: updated only in LATCH, so aborted windows leave them alone.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      result_bcd_out <= '0;
      result_ch_out  <= '0;
      dp_out         <= '0;
      overflow_out   <= 1'b0;
    end else if (latch_en) begin
      result_bcd_out <= count_q;
      result_ch_out  <= ch_q;
      dp_out         <= rng_q;
      overflow_out   <= ovf_q;
    end
  end

  // Valid flag: set by LATCH (taking priority over ack), cleared by ack.
  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      result_valid_out <= 1'b0;
    end else if (latch_en) begin
      result_valid_out <= 1'b1;
    end else if (result_ack_in) begin
      result_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_freq_counter_mc.sv
// Self-checking bench for bcd_freq_counter_mc. Each channel carries a square
// wave defined arithmetically by (half period, phase). The expected result of
// a window is the number of rising input levels that first appear at
// reference-clock samples inside that window, saturated at 10^DIGITS-1.
module tb_bcd_freq_counter_mc;

  localparam int CHANNELS    = 3;
  localparam int DIGITS      = 2;
  localparam int GATE_CYCLES = 1000;
  localparam int MAX_COUNT   = 99;

  logic                clk_ref_in       = 1'b0;
  logic                reset_in         = 1'b1;
  logic                enable_in        = 1'b0;
  logic [CHANNELS-1:0] clk_x_in         = '0;
  logic [1:0]          ch_sel_in        = '0;
  logic [1:0]          range_in         = '0;
  logic [4*DIGITS-1:0] result_bcd_out;
  logic [1:0]          result_ch_out;
  logic [1:0]          dp_out;
  logic                overflow_out;
  logic                result_valid_out;
  logic                result_ack_in    = 1'b0;
  logic                busy_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int half  [CHANNELS] = '{5, 2, 10};
  int phase [CHANNELS] = '{0, 3, 7};

  int cur_sel   = 0;
  int cur_rng   = 0;
  int win_start = 0;

  logic [4*DIGITS-1:0] last_bcd = '0;
  int                  last_ch  = 0;
  int                  last_dp  = 0;
  int                  last_ovf = 0;

  bcd_freq_counter_mc #(
    .CHANNELS    (CHANNELS),
    .DIGITS      (DIGITS),
    .GATE_CYCLES (GATE_CYCLES)
  ) dut (
    .clk_ref_in       (clk_ref_in),
    .reset_in         (reset_in),
    .enable_in        (enable_in),
    .clk_x_in         (clk_x_in),
    .ch_sel_in        (ch_sel_in),
    .range_in         (range_in),
    .result_bcd_out   (result_bcd_out),
    .result_ch_out    (result_ch_out),
    .dp_out           (dp_out),
    .overflow_out     (overflow_out),
    .result_valid_out (result_valid_out),
    .result_ack_in    (result_ack_in),
    .busy_out         (busy_out)
  );

  initial forever #5 clk_ref_in = ~clk_ref_in;

  always @(posedge clk_ref_in) cyc <= cyc + 1;

  // Input level of channel c as sampled at reference posedge number k.
  function automatic logic level(input int c, input int k);
    return (((k + phase[c]) / half[c]) % 2) == 1;
  endfunction

  // Drive on the falling edge the level the next rising edge will sample.
  always @(negedge clk_ref_in) begin
    for (int c = 0; c < CHANNELS; c++) begin
      clk_x_in[c] = level(c, cyc + 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int glen(input int rng);
    int g = GATE_CYCLES;
    for (int i = 0; i < rng; i++) g = g / 10;
    return g;
  endfunction

  function automatic int exp_rises(input int c, input int start, input int len);
    int n = 0;
    for (int k = start; k < start + len; k++) begin
      if (level(c, k) && !level(c, k - 1)) n++;
    end
    return n;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r = '0;
    int t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_ref_in);
  endtask

  task automatic set_cfg(input int sel, input int rng);
    cur_sel   = sel;
    cur_rng   = rng;
    ch_sel_in = 2'(sel);
    range_in  = 2'(rng);
  endtask

  // Called at a falling edge with the DUT idle; enable is sampled next edge.
  task automatic start_run();
    enable_in = 1'b1;
    win_start = cyc + 1;
  endtask

  // Follow one window to its result; optionally ack mid-gate or during LATCH,
  // and drop enable during LATCH when this is the last window of the run.
  task automatic do_window(input bit last, input bit ack_latch, input int ack_mid);
    int sel = cur_sel;
    int rng = cur_rng;
    int ch  = (cur_sel >= CHANNELS) ? 0 : cur_sel;
    int len = glen(cur_rng);
    int n;
    int ovf;
    if (ack_mid > 0) begin
      wait_cyc(win_start + ack_mid);
      result_ack_in = 1'b1;
      @(negedge clk_ref_in);
      result_ack_in = 1'b0;
      check("valid_cleared_by_ack", 32'(result_valid_out), 32'd0);
      check("busy_in_gate", 32'(busy_out), 32'd1);
    end
    wait_cyc(win_start + len + 1);
    if (last) enable_in = 1'b0;
    if (ack_latch) result_ack_in = 1'b1;
    @(negedge clk_ref_in);
    result_ack_in = 1'b0;
    n   = exp_rises(ch, win_start, len);
    ovf = (n > MAX_COUNT) ? 1 : 0;
    if (ovf != 0) n = MAX_COUNT;
    check($sformatf("result_bcd sel%0d rng%0d", sel, rng), 32'(result_bcd_out), 32'(to_bcd(n)));
    check("result_ch", 32'(result_ch_out), 32'(ch));
    check("dp", 32'(dp_out), 32'(rng));
    check("overflow", 32'(overflow_out), 32'(ovf));
    check("valid_after_latch", 32'(result_valid_out), 32'd1);
    check("busy_after_latch", 32'(busy_out), last ? 32'd0 : 32'd1);
    last_bcd  = to_bcd(n);
    last_ch   = ch;
    last_dp   = rng;
    last_ovf  = ovf;
    win_start = win_start + len + 2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bcd"},   32'(result_bcd_out),   32'd0);
    check({tag, "_ch"},    32'(result_ch_out),    32'd0);
    check({tag, "_dp"},    32'(dp_out),           32'd0);
    check({tag, "_ovf"},   32'(overflow_out),     32'd0);
    check({tag, "_valid"}, 32'(result_valid_out), 32'd0);
    check({tag, "_busy"},  32'(busy_out),         32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nwin;
    int bit_seen;
    reset_in = 1'b1;
    repeat (3) @(negedge clk_ref_in);
    check_all_zero("reset");
    reset_in = 1'b0;
    repeat (4) @(negedge clk_ref_in);

    // Directed run: ch0 period 10, ch1 period 4, ch2 period 20; six
    // back-to-back windows, never fully acked.
    set_cfg(0, 1);
    start_run();
    do_window(1'b0, 1'b0, 0);             // 100-cycle gate, period 10 -> 10
    set_cfg(0, 0);
    do_window(1'b0, 1'b0, 500);           // 100 edges -> saturates at 99
    set_cfg(1, 0);
    do_window(1'b0, 1'b1, 0);             // 250 edges -> 99, ack meets LATCH
    set_cfg(2, 0);
    do_window(1'b0, 1'b0, 0);             // 50 edges, no overflow
    set_cfg(3, 2);
    do_window(1'b0, 1'b0, 0);             // out-of-range select -> channel 0
    set_cfg(1, 3);
    do_window(1'b1, 1'b0, 0);             // single-cycle gate, last window

    // Randomized runs: new waveforms, selects, ranges and ack timing.
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        half[c]  = $urandom_range(2, 30);
        phase[c] = $urandom_range(0, 99);
      end
      wait_cyc(cyc + 4);
      nwin = $urandom_range(1, 3);
      for (int w = 0; w < nwin; w++) begin
        int rng = $urandom_range(0, 3);
        int am  = 0;
        set_cfg($urandom_range(0, 3), rng);
        if (w == 0) start_run();
        if (glen(rng) >= 100 && $urandom_range(0, 1) == 1) am = $urandom_range(1, glen(rng) - 2);
        do_window(w == nwin - 1, 1'($urandom_range(0, 1)), am);
      end
    end

    // Abort by dropping enable mid-gate: no result, no valid pulse.
    result_ack_in = 1'b1;
    @(negedge clk_ref_in);
    result_ack_in = 1'b0;
    check("valid_cleared_idle", 32'(result_valid_out), 32'd0);
    set_cfg(1, 0);
    start_run();
    wait_cyc(win_start + 300);
    enable_in = 1'b0;
    @(negedge clk_ref_in);
    check("busy_after_abort", 32'(busy_out), 32'd0);
    bit_seen = 0;
    repeat (1100) begin
      @(negedge clk_ref_in);
      if (result_valid_out !== 1'b0 || busy_out !== 1'b0) bit_seen = 1;
    end
    check("no_activity_after_abort", 32'(bit_seen), 32'd0);
    check("abort_keeps_bcd", 32'(result_bcd_out), 32'(last_bcd));
    check("abort_keeps_ch", 32'(result_ch_out), 32'(last_ch));
    check("abort_keeps_dp", 32'(dp_out), 32'(last_dp));
    check("abort_keeps_ovf", 32'(overflow_out), 32'(last_ovf));

    // One more window so the outputs are non-zero, then reset mid-gate.
    set_cfg(2, 1);
    start_run();
    do_window(1'b1, 1'b0, 0);
    set_cfg(0, 0);
    start_run();
    wait_cyc(win_start + 500);
    check("busy_before_reset", 32'(busy_out), 32'd1);
    reset_in = 1'b1;
    #1;
    check_all_zero("midgate_reset");
    enable_in = 1'b0;
    @(negedge clk_ref_in);
    reset_in = 1'b0;
    repeat (1010) @(negedge clk_ref_in);
    check_all_zero("after_reset_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
